mc_main_ctrl: RTL and testbench

- Parametrised second-generation main control FSM for the multicycle RV32I datapath; drives all datapath mux selects and write strobes.
- Adds over the first-generation decoder:
  - a variable-latency memory handshake (mem_req/mem_ready) with a wait-state timeout;
  - LUI, AUIPC, JALR and BLTU/BGEU;
  - a sticky fault state for illegal opcodes or memory timeout.
- Sits between the instruction register and the datapath; mc_alu_decoder consumes ALUOp.

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_wait_timer.sv | 30 +++
 rtl/mc_main_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, opcodes and select encodings for the multicycle RV32I control FSM
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12,
    S_JALRADR  = 4'd13,
    S_FAULT    = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // One-hot {bgeu,bltu,bge,blt,bne,beq}; non-branch codes give 0.
  function automatic logic [5:0] branch_onehot(input logic [2:0] f3);
    logic [5:0] bt;
    bt = 6'b000000;
    case (f3)
      F3_BEQ:  bt = 6'b000001;
      F3_BNE:  bt = 6'b000010;
      F3_BLT:  bt = 6'b000100;
      F3_BGE:  bt = 6'b001000;
      F3_BLTU: bt = 6'b010000;
      F3_BGEU: bt = 6'b100000;
      default: bt = 6'b000000;
    endcase
    return bt;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait-state counter; expired flags the cycle a stalled access must give up
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic wait_en,
  output logic expired
);

  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] count;

  // Saturates at LIMIT so a zero-timeout build never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wait_en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (MEM_TIMEOUT > 0) && wait_en && (count == LIMIT);

endmodule

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multicycle RV32I main control FSM with memory handshake and sticky fault
// Optional retired-instruction counter enabled by defining INSTRET_CNT_EN.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             PCUpdate,
  output logic             AddrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [5:0]       branch_type,
  output logic             fault,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_next;
  logic   expired, wait_en, wait_clear;
  logic   req_d, reg_write_d, pc_update_d, mem_write_d, ir_write_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  assign wait_en    = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE)) && !mem_ready;
  // Any state change restarts the count, covering MEMWRITE -> FETCH back-to-back accesses.
  assign wait_clear = (state_next != state);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .wait_en (wait_en),
    .expired (expired)
  );

  always_comb begin
    state_next  = state;
    req_d       = 1'b0;
    reg_write_d = 1'b0;
    pc_update_d = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    AddrSrc     = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    branch_type = 6'b000000;
    fault       = 1'b0;
    case (state)
      S_FETCH: begin
        req_d       = 1'b1;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_FOUR;
        ALUOp       = ALUOP_ADD;
        ResultSrc   = RES_ALURESULT;
        ir_write_d  = mem_ready;
        pc_update_d = mem_ready;
        if (mem_ready)    state_next = S_DECODE;
        else if (expired) state_next = S_FAULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = (funct3[2:1] == 2'b01) ? S_FAULT : S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALRADR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        req_d   = 1'b1;
        AddrSrc = 1'b1;
        if (mem_ready)    state_next = S_MEMWB;
        else if (expired) state_next = S_FAULT;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_d = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        req_d       = 1'b1;
        AddrSrc     = 1'b1;
        mem_write_d = 1'b1;
        if (mem_ready)    state_next = S_FETCH;
        else if (expired) state_next = S_FAULT;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc   = RES_ALUOUT;
        reg_write_d = 1'b1;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALUOUT;
        pc_update_d = 1'b1;
        state_next  = S_ALUWB;
      end
      S_JALRADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_JAL;
      end
      S_BRANCH: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_BRANCH;
        ResultSrc   = RES_ALUOUT;
        branch_type = branch_onehot(funct3);
        state_next  = S_FETCH;
      end
      S_FAULT: begin
        fault      = 1'b1;
        state_next = S_FAULT;
      end
      default: state_next = S_FAULT;
    endcase
  end

  // Strobes are masked by reset directly so an access is abandoned the instant reset falls.
  assign mem_req  = reset & req_d;
  assign RegWrite = reset & reg_write_d;
  assign PCUpdate = reset & pc_update_d;
  assign MemWrite = reset & mem_write_d;
  assign IRWrite  = reset & ir_write_d;
  assign state_o  = state;

`ifdef INSTRET_CNT_EN
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if ((state_next == S_FETCH) && (state != S_FETCH) && (state != S_FAULT)) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - directed table-driven bench for mc_main_ctrl
module tb_mc_main_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req;
  logic [1:0]  ResultSrc, ALUOp, ALUSrcA, ALUSrcB;
  logic        RegWrite, PCUpdate, AddrSrc, MemWrite, IRWrite;
  logic [5:0]  branch_type;
  logic        fault;
  logic [3:0]  state_o;
  logic [31:0] instret;

  int n_checks = 0;
  int n_fail = 0;
  int exp_instret = 0;

  mc_main_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .ResultSrc   (ResultSrc),
    .ALUOp       (ALUOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .PCUpdate    (PCUpdate),
    .AddrSrc     (AddrSrc),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .branch_type (branch_type),
    .fault       (fault),
    .state_o     (state_o),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    int          len;
    logic [23:0] seq;
    logic [5:0]  bt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] s6(input int a, input int b, input int c,
                                     input int d, input int e, input int f);
    return {4'(f), 4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // {ResultSrc, ALUOp, ALUSrcA, ALUSrcB} expected for each state
  function automatic logic [7:0] exp_ctrl(input logic [3:0] st);
    case (st)
      4'd0:  return {2'b10, 2'b00, 2'b00, 2'b10};
      4'd1:  return {2'b00, 2'b00, 2'b01, 2'b01};
      4'd2:  return {2'b00, 2'b00, 2'b10, 2'b01};
      4'd4:  return {2'b01, 2'b00, 2'b00, 2'b00};
      4'd6:  return {2'b00, 2'b10, 2'b10, 2'b00};
      4'd8:  return {2'b00, 2'b10, 2'b10, 2'b01};
      4'd9:  return {2'b00, 2'b00, 2'b01, 2'b10};
      4'd10: return {2'b00, 2'b01, 2'b10, 2'b00};
      4'd11: return {2'b00, 2'b00, 2'b11, 2'b01};
      4'd12: return {2'b00, 2'b00, 2'b01, 2'b01};
      4'd13: return {2'b00, 2'b00, 2'b10, 2'b01};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] exp_ir();
`ifdef INSTRET_CNT_EN
    return 32'(exp_instret);
`else
    return 32'd0;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_instret = 0;
  endtask

  initial begin
    logic [3:0] st;
    logic [3:0] last;
    logic [7:0] ctrl;

    vecs[0]  = '{7'b0110011, 3'b000, 4, s6(0, 1, 6, 7, 0, 0), 6'b000000};
    vecs[1]  = '{7'b0010011, 3'b000, 4, s6(0, 1, 8, 7, 0, 0), 6'b000000};
    vecs[2]  = '{7'b0000011, 3'b010, 5, s6(0, 1, 2, 3, 4, 0), 6'b000000};
    vecs[3]  = '{7'b0100011, 3'b010, 4, s6(0, 1, 2, 5, 0, 0), 6'b000000};
    vecs[4]  = '{7'b0110111, 3'b000, 4, s6(0, 1, 11, 7, 0, 0), 6'b000000};
    vecs[5]  = '{7'b0010111, 3'b000, 4, s6(0, 1, 12, 7, 0, 0), 6'b000000};
    vecs[6]  = '{7'b1101111, 3'b000, 4, s6(0, 1, 9, 7, 0, 0), 6'b000000};
    vecs[7]  = '{7'b1100111, 3'b000, 5, s6(0, 1, 13, 9, 7, 0), 6'b000000};
    vecs[8]  = '{7'b1100011, 3'b000, 3, s6(0, 1, 10, 0, 0, 0), 6'b000001};
    vecs[9]  = '{7'b1100011, 3'b001, 3, s6(0, 1, 10, 0, 0, 0), 6'b000010};
    vecs[10] = '{7'b1100011, 3'b100, 3, s6(0, 1, 10, 0, 0, 0), 6'b000100};
    vecs[11] = '{7'b1100011, 3'b101, 3, s6(0, 1, 10, 0, 0, 0), 6'b001000};
    vecs[12] = '{7'b1100011, 3'b110, 3, s6(0, 1, 10, 0, 0, 0), 6'b010000};
    vecs[13] = '{7'b1100011, 3'b111, 3, s6(0, 1, 10, 0, 0, 0), 6'b100000};
    vecs[14] = '{7'b1111111, 3'b000, 3, s6(0, 1, 14, 0, 0, 0), 6'b000000};
    vecs[15] = '{7'b1100011, 3'b010, 3, s6(0, 1, 14, 0, 0, 0), 6'b000000};
    vecs[16] = '{7'b1100011, 3'b011, 3, s6(0, 1, 14, 0, 0, 0), 6'b000000};
    vecs[17] = '{7'b0000000, 3'b000, 3, s6(0, 1, 14, 0, 0, 0), 6'b000000};

    // Reset state, including strobes masked while reset is low
    mem_ready = 1'b1;
    #2;
    check("rst state", 32'(state_o), 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst IRWrite", 32'(IRWrite), 32'd0);
    check("rst PCUpdate", 32'(PCUpdate), 32'd0);
    check("rst instret", instret, 32'd0);
    tick();
    reset = 1'b1;

    for (int v = 0; v < 18; v++) begin
      opcode = vecs[v].op;
      funct3 = vecs[v].f3;
      mem_ready = 1'b1;
      #1;
      last = 4'd0;
      for (int i = 0; i < vecs[v].len; i++) begin
        st = vecs[v].seq[i*4 +: 4];
        last = st;
        ctrl = exp_ctrl(st);
        check($sformatf("v%0d c%0d state", v, i), 32'(state_o), 32'(st));
        check($sformatf("v%0d c%0d mem_req", v, i), 32'(mem_req), 32'(st == 0 || st == 3 || st == 5));
        check($sformatf("v%0d c%0d RegWrite", v, i), 32'(RegWrite), 32'(st == 4 || st == 7));
        check($sformatf("v%0d c%0d PCUpdate", v, i), 32'(PCUpdate), 32'(st == 0 || st == 9));
        check($sformatf("v%0d c%0d IRWrite", v, i), 32'(IRWrite), 32'(st == 0));
        check($sformatf("v%0d c%0d MemWrite", v, i), 32'(MemWrite), 32'(st == 5));
        check($sformatf("v%0d c%0d AddrSrc", v, i), 32'(AddrSrc), 32'(st == 3 || st == 5));
        check($sformatf("v%0d c%0d fault", v, i), 32'(fault), 32'(st == 14));
        check($sformatf("v%0d c%0d branch_type", v, i), 32'(branch_type),
              32'((st == 10) ? vecs[v].bt : 6'b0));
        check($sformatf("v%0d c%0d ctrl", v, i), 32'({ResultSrc, ALUOp, ALUSrcA, ALUSrcB}), 32'(ctrl));
        tick();
      end
      if (last == 4'd14) begin
        check($sformatf("v%0d sticky state", v), 32'(state_o), 32'd14);
        check($sformatf("v%0d sticky fault", v), 32'(fault), 32'd1);
        do_reset();
        check($sformatf("v%0d post-reset state", v), 32'(state_o), 32'd0);
      end else begin
        exp_instret++;
        check($sformatf("v%0d back to fetch", v), 32'(state_o), 32'd0);
        check($sformatf("v%0d instret", v), instret, exp_ir());
      end
    end

    // Load with three wait cycles in MEMREAD
    opcode = 7'b0000011;
    funct3 = 3'b010;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ld wait%0d state", i), 32'(state_o), 32'd3);
      check($sformatf("ld wait%0d mem_req", i), 32'(mem_req), 32'd1);
      check($sformatf("ld wait%0d fault", i), 32'(fault), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("ld done state", 32'(state_o), 32'd3);
    check("ld done mem_req", 32'(mem_req), 32'd1);
    tick();
    check("ld memwb state", 32'(state_o), 32'd4);
    check("ld memwb ResultSrc", 32'(ResultSrc), 32'd1);
    check("ld memwb RegWrite", 32'(RegWrite), 32'd1);
    check("ld memwb mem_req", 32'(mem_req), 32'd0);
    tick();
    exp_instret++;
    check("ld fetch state", 32'(state_o), 32'd0);
    check("ld instret", instret, exp_ir());

    // mem_ready arrives on the very cycle the limit is reached: no fault
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("edge wait%0d state", i), 32'(state_o), 32'd0);
      check($sformatf("edge wait%0d IRWrite", i), 32'(IRWrite), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("edge IRWrite", 32'(IRWrite), 32'd1);
    check("edge PCUpdate", 32'(PCUpdate), 32'd1);
    tick();
    check("edge decode", 32'(state_o), 32'd1);
    check("edge no fault", 32'(fault), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    exp_instret++;
    check("edge load done", 32'(state_o), 32'd0);

    // FETCH starved past the limit -> FAULT, then reset recovers
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to wait%0d state", i), 32'(state_o), 32'd0);
      check($sformatf("to wait%0d IRWrite", i), 32'(IRWrite), 32'd0);
      check($sformatf("to wait%0d PCUpdate", i), 32'(PCUpdate), 32'd0);
      tick();
    end
    check("to state", 32'(state_o), 32'd14);
    check("to fault", 32'(fault), 32'd1);
    check("to mem_req", 32'(mem_req), 32'd0);
    check("to IRWrite", 32'(IRWrite), 32'd0);
    mem_ready = 1'b1;
    tick();
    check("to sticky", 32'(state_o), 32'd14);
    reset = 1'b0;
    #1;
    check("to async state", 32'(state_o), 32'd0);
    check("to async fault", 32'(fault), 32'd0);
    tick();
    reset = 1'b1;
    exp_instret = 0;
    check("to instret cleared", instret, exp_ir());

    // Reset pulled mid-MEMWRITE drops the strobes at once
    opcode = 7'b0100011;
    funct3 = 3'b010;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("st state", 32'(state_o), 32'd5);
    check("st MemWrite", 32'(MemWrite), 32'd1);
    check("st mem_req", 32'(mem_req), 32'd1);
    tick();
    check("st held MemWrite", 32'(MemWrite), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("st rst MemWrite", 32'(MemWrite), 32'd0);
    check("st rst mem_req", 32'(mem_req), 32'd0);
    check("st rst state", 32'(state_o), 32'd0);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("st restart mem_req", 32'(mem_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
